mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the multi-cycle datapath's single-port word memory between the CPU (master 0) and a program loader/debug port (master 1). Requests are accepted with a one-cycle grant, the access is presented to the memory for one cycle, and a registered response is returned to the winning master. It also checks alignment and range, so the memory never sees an illegal access. It sits between the requesters and the memory's clk/we/a/wd/rd pins.

## Interface
- DEPTH, 64: memory size in 32-bit words; legal word index is 0..DEPTH-1.
- AW, 32: byte-address width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held with fields stable until grant.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  AW  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_gnt / m1_gnt  out  1  request sampled at this clock edge (combinational).
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse.
- m0_rdata / m1_rdata  out  32  read data; meaningful only with rvalid.
- m0_err / m1_err  out  1  qualifies rvalid: access rejected.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory byte address, word aligned.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Arbitration happens in IDLE and RESP.
  - If any req is high, exactly one gnt is high that cycle.
  - On the edge, addr/we/wdata/master id are latched, the error flag is computed, and the FSM goes to ACCESS.
  - If no req is high, the FSM stays in (or goes to) IDLE.
- ACCESS:
  - mem_a = latched address with bits [1:0] forced to 0.
  - mem_wd = latched wdata.
  - mem_we = latched we AND NOT err.
  - mem_rd is captured into the response register: 0 on a write or on an error.
  - Next state is RESP.
- RESP:
  - rvalid of the latched master is high; rdata and err come from the response register.
  - The other master's rvalid stays 0.
- Error condition: addr[1:0] != 0 OR addr[AW-1:2] >= DEPTH.
  - The memory is not written.
  - Response is rdata = 0, err = 1.
- Grants are never issued in ACCESS. At most one access is outstanding.
- mem_a and mem_wd hold their last value outside ACCESS; mem_we is 0 outside ACCESS.
- Reset values: all gnt = 0, rvalid = 0, rdata = 0, err = 0, mem_we = 0, mem_a = 0, mem_wd = 0. Round-robin pointer = "m1 last".
- Reset mid-operation:
  - An in-flight access is dropped: no write, no rvalid.
  - A gnt in the reset cycle is suppressed.

## Timing
- Request in cycle T (FSM in IDLE or RESP): gnt in T.
- Memory access in T+1: the write commits at the end of T+1.
- rvalid in T+2.
- Back-to-back: the next grant can occur in T+2, the same cycle as rvalid. Peak rate is one access per 2 cycles.
- Read after write: a read granted in a write's RESP cycle sees the new data.
- Requester rule: deassert req or present new fields the cycle after gnt. Keeping req high requests another access.

## Configuration
- MEM_ARB_RR_EN defined: round-robin.
  - On simultaneous requests, the master not granted last wins.
  - The pointer updates on every grant.
  - After reset, m0 wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, m0 always wins a tie. No pointer register is built.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - master id constants M_CPU = 0 and M_LDR = 1;
  - the word-index helper (addr[AW-1:2]).
- Sub-module mem_arb_pick: combinational winner select from req[1:0] and the last-grant pointer. It is also compiled under MEM_ARB_RR_EN.

## Test plan
- Single read: m0 reads 0x08 holding 0xDEADBEEF → m0_gnt in T, mem_a = 0x08 in T+1, m0_rvalid with rdata 0xDEADBEEF and err = 0 in T+2.
- Write then read: m1 writes 0x12345678 to 0x10, then reads 0x10 in its RESP cycle → mem_we = 1 for exactly one cycle, and the read returns 0x12345678.
- Contention, both req held high for 4 grants:
  - MEM_ARB_RR_EN: grants m0, m1, m0, m1.
  - Without the macro: m0 every time, m1 starved.
- Errors:
  - m0 reads 0x06 → err = 1, rdata = 0, mem_we stays 0.
  - m1 writes 0x100 with DEPTH = 64 → err = 1, memory unchanged.
- Reset in the ACCESS cycle of a write to 0x20: memory at 0x20 unchanged, no rvalid, all outputs at reset values the next cycle; a request the next cycle is granted normally.
- Idle: no req for 10 cycles → no gnt, no rvalid, mem_we = 0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the word-index helper for the memory arbiter.
// Build option used by this block: MEM_ARB_RR_EN (round-robin tie break).
package mem_arb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [AW-3:0] word_idx(input logic [AW-1:0] addr);
    return addr[AW-1:2];
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bus of the memory arbiter: two masters, each with a
// request/grant handshake and a registered response.
interface mem_arb_if #(
  parameter int AW = mem_arb_pkg::AW,
  parameter int DW = mem_arb_pkg::DW
);

  // Handshake: a master holds req with stable we/addr/wdata until gnt is seen
  // high in the same cycle; on the following cycle it drops req or presents
  // the next access. Exactly two cycles after gnt the arbiter pulses rvalid
  // for one cycle; rdata and err are meaningful only while rvalid is high.
  logic          m0_req,    m1_req;
  logic          m0_we,     m1_we;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [DW-1:0] m0_wdata,  m1_wdata;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;
  logic          m0_err,    m1_err;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the two requesters.
// With MEM_ARB_RR_EN a tie goes to the master not granted last; otherwise m0 wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      pick = (last == M_CPU) ? 2'b10 : 2'b01;
`else
      pick = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port word memory with alignment and
// range checking. Build option: MEM_ARB_RR_EN selects round-robin tie break.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  mem_arb_if.slave      bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output state_e        dbg_state
);

  localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

  state_e        state, state_nx;
  logic [1:0]    req, pick, gnt;
  logic          arb_phase;
  logic          sel_id, sel_we, sel_err;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          lat_id, lat_we, lat_err;
  logic [AW-3:0] lat_word;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          rvalid;

  assign req = {bus.m1_req, bus.m0_req};

  // Grants only in IDLE/RESP, and never in a reset cycle.
  assign arb_phase = ((state == IDLE) || (state == RESP)) && !reset;

`ifdef MEM_ARB_RR_EN
  logic last;

  mem_arb_pick u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= M_LDR;
    end else if (|gnt) begin
      last <= sel_id;
    end
  end
`else
  mem_arb_pick u_pick (
    .req  (req),
    .pick (pick)
  );
`endif

  assign gnt = pick & {2{arb_phase}};

  always_comb begin
    sel_id    = gnt[1] ? M_LDR : M_CPU;
    sel_we    = bus.m0_we;
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    if (sel_id == M_LDR) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
    sel_err = (sel_addr[1:0] != 2'b00) || (word_idx(sel_addr) >= DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RESP: state_nx = (|gnt) ? ACCESS : IDLE;
      ACCESS:     state_nx = RESP;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_id    <= M_CPU;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_word  <= '0;
      lat_wdata <= '0;
    end else if (|gnt) begin
      lat_id    <= sel_id;
      lat_we    <= sel_we;
      lat_err   <= sel_err;
      lat_word  <= word_idx(sel_addr);
      lat_wdata <= sel_wdata;
    end
  end

  // Writes and rejected accesses return zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (state == ACCESS) begin
      resp_data <= (lat_we || lat_err) ? '0 : mem_rd;
      resp_err  <= lat_err;
    end
  end

  // Reset gating on mem_we drops a write caught in its ACCESS cycle.
  assign mem_we = (state == ACCESS) && lat_we && !lat_err && !reset;
  assign mem_a  = {lat_word, 2'b00};
  assign mem_wd = lat_wdata;

  assign rvalid = (state == RESP) && !reset;

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid && (lat_id == M_CPU);
  assign bus.m1_rvalid = rvalid && (lat_id == M_LDR);
  assign bus.m0_rdata  = resp_data;
  assign bus.m1_rdata  = resp_data;
  assign bus.m0_err    = bus.m0_rvalid && resp_err;
  assign bus.m1_err    = bus.m1_rvalid && resp_err;

  assign dbg_state = state;

endmodule
